// File: rtl/uart_tx_buffered_if.sv
// Character handshake between the CPU transmit register and the UART.
// The producer drives data/valid; the UART answers with ready.
interface uart_tx_buffered_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter, LSB first,
// frames sent back-to-back while characters are queued.
module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  uart_tx_buffered_if.slave               in_if,
  output logic                            serial_out,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int SET  = CLOCK_FREQ / BAUD_RATE;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int CNTW = $clog2(SET);
  localparam logic [CW-1:0]   FULL = CW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(SET - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  state_t          state_q;
  logic [9:0]      shift_q;
  logic [3:0]      bit_q;
  logic [CNTW-1:0] cnt_q;
  logic            ser_q;

  logic       push;
  logic       pop;
  logic       empty;
  logic       last_edge;
  logic [7:0] head;

  assign empty     = (count_q == '0);
  assign last_edge = (cnt_q == LAST);
  assign head      = mem_q[rd_ptr_q];

  // Ready comes only from the registered count, so a pop never bypasses.
  assign in_if.data_in_ready = (count_q != FULL);
  assign push = in_if.data_in_valid && in_if.data_in_ready;

  assign serial_out = ser_q;
  assign tx_busy    = (state_q == SEND) || !empty;
  assign fifo_count = count_q;

  // Pop when idle, or at the close of a stop bit to chain the next frame.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state_q == IDLE) pop = 1'b1;
      else if (last_edge && bit_q == 4'd9) pop = 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Character storage; contents need no reset, pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.data_in;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Transmit FSM with registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          ser_q <= 1'b1;
          if (pop) begin
            shift_q <= {1'b1, head, 1'b0};
            bit_q   <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!last_edge) begin
            cnt_q <= cnt_q + CNTW'(1);
          end else begin
            cnt_q <= '0;
            if (bit_q != 4'd9) begin
              bit_q   <= bit_q + 4'd1;
              shift_q <= {1'b1, shift_q[9:1]};
              ser_q   <= shift_q[1];
            end else if (pop) begin
              shift_q <= {1'b1, head, 1'b0};
              bit_q   <= '0;
              ser_q   <= 1'b0;
            end else begin
              ser_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: 5 cycles per bit, depth-8 FIFO,
// line decoded by a mid-bit sampling receiver model.
module tb_uart_tx_buffered;
  localparam int SET = 5;
  localparam int FL  = 10 * SET;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  uart_tx_buffered_if vin();

  uart_tx_buffered #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (10_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (vin.slave),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int timeouts = 0;
  int frame_err = 0;
  int maxcnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  int         rx_start[$];
  logic [9:0] rx_bits;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Receiver model: find a start bit, sample each bit at its centre.
  logic [9:0] mb;
  bit         mab;
  int         mst;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && serial_out === 1'b0) begin
        mst = cyc;
        mab = 1'b0;
        mb  = '0;
        repeat (SET / 2) begin
          @(negedge clk);
          if (rst) mab = 1'b1;
        end
        mb[0] = serial_out;
        for (int i = 1; i < 10; i++) begin
          repeat (SET) begin
            @(negedge clk);
            if (rst) mab = 1'b1;
          end
          mb[i] = serial_out;
        end
        if (!mab) begin
          if (mb[0] !== 1'b0 || mb[9] !== 1'b1) frame_err++;
          rx_data.push_back(mb[8:1]);
          rx_start.push_back(mst);
          rx_bits = mb;
        end
        repeat (SET - 1 - SET / 2) @(negedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
  end

  int hs_cyc;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b);
    int t;
    t = 0;
    vin.data_in       = b;
    vin.data_in_valid = 1'b1;
    while (vin.data_in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) timeouts++;
    hs_cyc = cyc + 1;
    exp_q.push_back(b);
    @(negedge clk);
    vin.data_in       = 8'($urandom);
    vin.data_in_valid = 1'b0;
  endtask

  task automatic drain(output int drop);
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) timeouts++;
    drop = cyc;
    repeat (SET) @(negedge clk);
  endtask

  task automatic clear();
    exp_q.delete();
    rx_data.delete();
    rx_start.delete();
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++)
      chk(tag, rx_data[i], exp_q[i]);
  endtask

  int         drop;
  int         acc;
  int         n0;
  int         sent;
  int         t;
  bit         stalled;
  bit         line_hi;
  logic [7:0] d;
  logic [9:0] fr;
  logic [7:0] burst[5];

  initial begin
    vin.data_in       = 8'h00;
    vin.data_in_valid = 1'b0;
    burst = '{8'h31, 8'h35, 8'h31, 8'h3e, 8'h20};

    // Reset and idle
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_ready", vin.data_in_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_count", fifo_count, 4'd0);
    line_hi = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1) line_hi = 1'b0;
    end
    chk("idle_line", line_hi, 1'b1);

    // Single character
    clear();
    push(8'h61);
    drain(drop);
    chk("single_frames", rx_data.size(), 1);
    chk("single_latency", rx_start[0], hs_cyc + 1);
    fr = {1'b1, 8'h61, 1'b0};
    for (int i = 0; i < 10; i++) chk("single_bit", rx_bits[i], fr[i]);
    chk("single_busy_drop", drop - rx_start[0], FL);
    cmp_stream("single_data");

    // Burst on consecutive cycles
    clear();
    for (int i = 0; i < 5; i++) push(burst[i]);
    drain(drop);
    cmp_stream("burst_data");
    for (int i = 1; i < rx_start.size(); i++)
      chk("burst_gap", rx_start[i] - rx_start[i-1], FL);
    chk("burst_total", drop - rx_start[0], 5 * FL);
    chk("frame_errors", frame_err, 0);

    // Full FIFO
    clear();
    acc = 0;
    stalled = 1'b0;
    d = 8'h00;
    vin.data_in       = d;
    vin.data_in_valid = 1'b1;
    for (int k = 0; k < 100 && !stalled; k++) begin
      if (vin.data_in_ready === 1'b1) begin
        exp_q.push_back(d);
        d = d + 8'd1;
        acc++;
        @(negedge clk);
        vin.data_in = d;
      end else begin
        stalled = 1'b1;
        chk("full_count", fifo_count, 4'd8);
      end
    end
    vin.data_in_valid = 1'b0;
    chk("full_stalled", stalled, 1'b1);
    chk("full_accepted", acc, 9);
    drain(drop);
    cmp_stream("full_data");

    // Pointer wrap with random bursts
    clear();
    maxcnt = 0;
    sent = 0;
    while (sent < 20) begin
      n0 = $urandom_range(1, 6);
      for (int i = 0; i < n0 && sent < 20; i++) begin
        push(8'($urandom));
        sent++;
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    drain(drop);
    cmp_stream("wrap_data");
    chk("wrap_maxcount_ok", maxcnt <= 8, 1'b1);

    // Reset mid-frame
    clear();
    push(8'hca);
    n0 = hs_cyc + 1;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    t = 0;
    while (cyc != n0 + 4 * SET + SET / 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) timeouts++;
    chk("pre_rst_bit3", serial_out, 1'b1);
    chk("pre_rst_count", fifo_count, 4'd3);
    rst = 1'b1;
    #1;
    chk("midrst_serial", serial_out, 1'b1);
    chk("midrst_count", fifo_count, 4'd0);
    chk("midrst_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = rx_data.size();
    line_hi = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1) line_hi = 1'b0;
    end
    chk("post_rst_quiet", line_hi, 1'b1);
    chk("post_rst_frames", rx_data.size(), n0);
    chk("post_rst_ready", vin.data_in_ready, 1'b1);
    clear();
    push(8'h5a);
    drain(drop);
    cmp_stream("recover_data");

    chk("timeouts", timeouts, 0);
    chk("frame_errors_end", frame_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

FIFO-buffered 8N1 UART transmitter for the CPU's memory-mapped serial port. It sits between the CPU's UART transmit register and the `serial_out` pin, and is the on-chip counterpart of the host receiver that samples `serial_out`. The CPU can queue up to FIFO_DEPTH characters with a ready/valid handshake. The block then sends them back-to-back, LSB first, with no idle gap between frames.

## Interface
- CLOCK_FREQ, 125_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- FIFO_DEPTH, 8: number of buffered characters; must be a power of two, at least 2.
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division), in cycles per bit. Must be at least 2.

- clk  in  1  system clock; the block uses this single clock only.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  character to transmit.
- data_in_valid  in  1  producer offers data_in this cycle.
- data_in_ready  out  1  block can accept a character; equals !full.
- serial_out  out  1  UART line, registered; idle level is 1.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued characters, not counting the frame being sent.

## Operation
- FIFO
  - Circular buffer with read and write pointers and an occupancy counter.
  - A push happens on a rising edge where data_in_valid && data_in_ready.
  - data_in_ready depends only on the registered count. A pop in the same cycle does not raise ready (no bypass).
  - A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Transmit FSM has two states, IDLE and SEND.
  - IDLE: serial_out = 1. If the FIFO is non-empty, pop the head and load a 10-bit shift register {1, data[7:0], 0}. Set bit_idx = 0 and the cycle counter to 0, drive serial_out = 0, and go to SEND.
  - SEND: the cycle counter counts 0 to SYMBOL_EDGE_TIME-1.
    - At terminal count, advance bit_idx and drive the next shift bit onto serial_out.
    - After bit 9 (the stop bit) completes its full SYMBOL_EDGE_TIME: if the FIFO is non-empty, pop and start the next start bit on the same edge (no idle cycle). Otherwise return to IDLE.
- Line order: start bit 0, then data[0] through data[7], then stop bit 1. Each bit is held exactly SYMBOL_EDGE_TIME cycles, so a frame lasts 10·SYMBOL_EDGE_TIME cycles.
- tx_busy = (state == SEND) || (fifo_count != 0).

## Timing
- Reset values: serial_out = 1, data_in_ready = 1, tx_busy = 0, fifo_count = 0, state = IDLE. Pointers, counters and the shift register are cleared.
- Reset mid-frame aborts the frame. serial_out goes to 1 asynchronously and the FIFO contents are discarded.
- Latency: suppose a character is accepted at edge N into an empty FIFO while the FSM is in IDLE.
  - fifo_count = 1 after edge N.
  - The pop at edge N+1 drives serial_out low; fifo_count returns to 0 after edge N+1.
- Full FIFO: data_in_ready = 0 and offered data is not taken. Ready rises one cycle after the pop that frees a slot.
- The data_in value for a push is sampled at the accepting edge only; later changes do not affect the queued character.
- Frames are back-to-back whenever the FIFO is non-empty at the end of a stop bit.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 10 cycles, then release.
  - Required: serial_out = 1, data_in_ready = 1, tx_busy = 0, fifo_count = 0, and serial_out stays 1 for 100 cycles.
- Single character, with CLOCK_FREQ = 50_000_000 and BAUD_RATE = 10_000_000 (5 cycles per bit):
  - Stimulus: push 8'h61.
  - Required: the start bit begins one cycle after the handshake. Sampling mid-bit yields 0,1,0,0,0,0,1,1,0,1 (bits 0–9). tx_busy drops exactly 50 cycles after the start bit begins.
- Burst: push "151> " (8'h31, 8'h35, 8'h31, 8'h3e, 8'h20) on consecutive cycles.
  - Required: five frames with no idle gap between them.
  - Required: every character is decoded correctly in order, and the total line activity is 250 cycles.
- Full FIFO (FIFO_DEPTH = 8): hold data_in_valid high with incrementing data 8'h00 onward.
  - Required: data_in_ready = 0 once fifo_count = 8.
  - Required: 9 characters are accepted before the first stall (one is popped into the shift register).
  - Required: characters 8'h00–8'h08 are then decoded in order with no losses or duplicates.
- Pointer wrap: send 20 characters through the depth-8 FIFO in random-length bursts.
  - Required: all 20 are decoded in order, and fifo_count never exceeds 8.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3 of 8'hca, with 3 characters queued.
  - Required: serial_out = 1 immediately and fifo_count = 0. No further frames appear after reset is released until a new push.
